// File: rtl/health_alarm_pkg.sv
// Shared types and constants for the health alarm controller.
// State encoding, condition bit positions, alarm codes, priority encoder.
package health_alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ALARM    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    localparam int COND_W  = 6;
    localparam int NUM_DEB = 5;
    localparam int DEB_W   = 4;

    localparam int BIT_GI    = 0;
    localparam int BIT_HIGH  = 1;
    localparam int BIT_LOW   = 2;
    localparam int BIT_BLOOD = 3;
    localparam int BIT_PRESS = 4;
    localparam int BIT_FALL  = 5;

    localparam logic [2:0] CODE_NONE  = 3'd0;
    localparam logic [2:0] CODE_FALL  = 3'd1;
    localparam logic [2:0] CODE_PRESS = 3'd2;
    localparam logic [2:0] CODE_BLOOD = 3'd3;
    localparam logic [2:0] CODE_LOW   = 3'd4;
    localparam logic [2:0] CODE_HIGH  = 3'd5;
    localparam logic [2:0] CODE_GI    = 3'd6;

    // Fall outranks everything; glycemic index is the least urgent.
    function automatic logic [2:0] encode_alarm(
        input logic [COND_W-1:0] p
    );
        logic [2:0] code;
        code = CODE_NONE;
        if (p[BIT_FALL])       code = CODE_FALL;
        else if (p[BIT_PRESS]) code = CODE_PRESS;
        else if (p[BIT_BLOOD]) code = CODE_BLOOD;
        else if (p[BIT_LOW])   code = CODE_LOW;
        else if (p[BIT_HIGH])  code = CODE_HIGH;
        else if (p[BIT_GI])    code = CODE_GI;
        return code;
    endfunction

endpackage

// File: rtl/abnormality_debouncer.sv
// Per-condition debouncer: confirms after DEBOUNCE_CYCLES consecutive valid samples.
// Ports: clk, rst (sync, high), sampleValid, cond in; confirm out (combinational).
module abnormality_debouncer
    import health_alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sampleValid,
    input  logic cond,
    output logic confirm
);

    localparam logic [DEB_W-1:0] SAT = DEB_W'(DEBOUNCE_CYCLES);

    logic [DEB_W-1:0] r_count;
    logic [DEB_W-1:0] w_next;

    always_comb begin
        w_next = '0;
        if (cond) begin
            w_next = (r_count == SAT) ? SAT : r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (sampleValid) begin
            r_count <= w_next;
        end
    end

    // Level-based: stays high every valid sample while the condition persists.
    assign confirm = sampleValid & cond & (w_next == SAT);

endmodule

// File: rtl/health_alarm_controller.sv
// Debounces detector flags into a sticky pending set and drives a prioritised,
// acknowledged alarm with cooldown and a saturating alarm-event counter.
// Inputs : clk, rst, sampleValid, five abnormality flags, glycemicIndex[3:0], alarmAck.
// Outputs: alarmActive, alarmCode[2:0], alarmSources[5:0], eventCount[CNT_W-1:0].
module health_alarm_controller
    import health_alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GI_HIGH         = 12,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sampleValid,
    input  logic             presureAbnormality,
    input  logic             bloodAbnormality,
    input  logic             lowTempAbnormality,
    input  logic             highTempAbnormality,
    input  logic             fallDetected,
    input  logic [3:0]       glycemicIndex,
    input  logic             alarmAck,
    output logic             alarmActive,
    output logic [2:0]       alarmCode,
    output logic [5:0]       alarmSources,
    output logic [CNT_W-1:0] eventCount
);

    localparam int CD_W =
        (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [COND_W-1:0]  w_cond;
    logic [NUM_DEB-1:0] w_confirm;
    logic [COND_W-1:0]  w_set;
    logic [COND_W-1:0]  w_pending_next;
    logic               w_ack_take;

    state_t             r_state;
    logic [COND_W-1:0]  r_pending;
    logic [CD_W-1:0]    r_cooldown;
    logic [CNT_W-1:0]   r_events;

    assign w_cond[BIT_GI]    = (glycemicIndex >= 4'(GI_HIGH));
    assign w_cond[BIT_HIGH]  = highTempAbnormality;
    assign w_cond[BIT_LOW]   = lowTempAbnormality;
    assign w_cond[BIT_BLOOD] = bloodAbnormality;
    assign w_cond[BIT_PRESS] = presureAbnormality;
    assign w_cond[BIT_FALL]  = fallDetected;

    for (genvar g = 0; g < NUM_DEB; g++) begin : g_deb
        abnormality_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk        (clk),
            .rst        (rst),
            .sampleValid(sampleValid),
            .cond       (w_cond[g]),
            .confirm    (w_confirm[g])
        );
    end

    // A fall is acted on immediately, without debouncing.
    assign w_set = {sampleValid & fallDetected, w_confirm};

    assign w_ack_take = (r_state == ST_ALARM) & alarmAck;

    // OR-ing the set after the clear makes a same-edge set survive the ack.
    assign w_pending_next = (w_ack_take ? '0 : r_pending) | w_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_cooldown <= '0;
            r_events   <= '0;
        end else begin
            r_pending <= w_pending_next;
            unique case (r_state)
                ST_IDLE: begin
                    if (|r_pending) begin
                        r_state <= ST_ALARM;
                        if (r_events != CNT_MAX) begin
                            r_events <= r_events + 1'b1;
                        end
                    end
                end
                ST_ALARM: begin
                    if (alarmAck) begin
                        r_state    <= ST_COOLDOWN;
                        r_cooldown <= CD_LOAD;
                    end
                end
                ST_COOLDOWN: begin
                    if (r_cooldown == '0) begin
                        if (|r_pending) begin
                            r_state <= ST_ALARM;
                            if (r_events != CNT_MAX) begin
                                r_events <= r_events + 1'b1;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cooldown <= r_cooldown - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign alarmActive  = (r_state == ST_ALARM);
    assign alarmSources = r_pending;
    assign alarmCode    = (r_state == ST_ALARM) ?
                          encode_alarm(r_pending) : CODE_NONE;
    assign eventCount   = r_events;

endmodule

// File: tb/tb_health_alarm_controller.sv
// Self-checking bench for health_alarm_controller.
// Directed scenarios plus random traffic against a behavioural model.
module tb_health_alarm_controller;

    localparam int DEB = 4;
    localparam int GIH = 12;
    localparam int CD  = 8;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sampleValid = 1'b0;
    logic          presureAbnormality = 1'b0;
    logic          bloodAbnormality = 1'b0;
    logic          lowTempAbnormality = 1'b0;
    logic          highTempAbnormality = 1'b0;
    logic          fallDetected = 1'b0;
    logic [3:0]    glycemicIndex = 4'd0;
    logic          alarmAck = 1'b0;
    logic          alarmActive;
    logic [2:0]    alarmCode;
    logic [5:0]    alarmSources;
    logic [CW-1:0] eventCount;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: streak lengths, pending set, mode 0=idle 1=alarm 2=cooldown.
    int         streak [5];
    logic [5:0] m_pend = '0;
    int         m_mode = 0;
    int         m_cd   = 0;
    int         m_cnt  = 0;

    health_alarm_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .GI_HIGH        (GIH),
        .COOLDOWN_CYCLES(CD),
        .CNT_W          (CW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .sampleValid        (sampleValid),
        .presureAbnormality (presureAbnormality),
        .bloodAbnormality   (bloodAbnormality),
        .lowTempAbnormality (lowTempAbnormality),
        .highTempAbnormality(highTempAbnormality),
        .fallDetected       (fallDetected),
        .glycemicIndex      (glycemicIndex),
        .alarmAck           (alarmAck),
        .alarmActive        (alarmActive),
        .alarmCode          (alarmCode),
        .alarmSources       (alarmSources),
        .eventCount         (eventCount)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_code();
        if (m_mode != 1) return 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (m_pend[i]) return 3'(6 - i);
        end
        return 3'd0;
    endfunction

    task automatic drive(input logic v, input logic f, input logic pr,
                         input logic bl, input logic lo, input logic hi,
                         input logic [3:0] g, input logic a);
        sampleValid         = v;
        fallDetected        = f;
        presureAbnormality  = pr;
        bloodAbnormality    = bl;
        lowTempAbnormality  = lo;
        highTempAbnormality = hi;
        glycemicIndex       = g;
        alarmAck            = a;
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        logic [5:0] c;
        logic [5:0] setv;
        logic       clr;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 5; i++) streak[i] = 0;
            m_pend = '0;
            m_mode = 0;
            m_cd   = 0;
            m_cnt  = 0;
        end else begin
            c = {fallDetected, presureAbnormality, bloodAbnormality,
                 lowTempAbnormality, highTempAbnormality,
                 (int'(glycemicIndex) >= GIH)};
            setv = '0;
            if (sampleValid) begin
                for (int i = 0; i < 5; i++) begin
                    streak[i] = c[i] ? streak[i] + 1 : 0;
                    if (streak[i] > 100) streak[i] = 100;
                    if (streak[i] >= DEB) setv[i] = 1'b1;
                end
                setv[5] = c[5];
            end
            clr = 1'b0;
            if (m_mode == 0) begin
                if (m_pend != 0) begin
                    m_mode = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end else if (m_mode == 1) begin
                if (alarmAck) begin
                    m_mode = 2;
                    m_cd   = CD;
                    clr    = 1'b1;
                end
            end else begin
                m_cd--;
                if (m_cd == 0) begin
                    if (m_pend != 0) begin
                        m_mode = 1;
                        if (m_cnt < 255) m_cnt++;
                    end else begin
                        m_mode = 0;
                    end
                end
            end
            m_pend = (clr ? 6'd0 : m_pend) | setv;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 4'd0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({alarmActive, alarmCode, alarmSources, eventCount} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b/%0d/%b/%0d exp=all zero",
                     alarmActive, alarmCode, alarmSources, eventCount);
        end
        for (int k = 0; k < 20; k++) begin
            drive(1, 0, 0, 0, 0, 0, 4'($urandom_range(0, GIH - 1)), 0);
            tick();
            n_tests++;
            if ({alarmActive, alarmCode, alarmSources, eventCount} !== '0) begin
                n_fail++;
                $display("FAIL quiet_%0d got=%b/%0d/%b/%0d exp=all zero", k,
                         alarmActive, alarmCode, alarmSources, eventCount);
            end
        end
    endtask

    task automatic test_fall();
        apply_reset();
        drive(1, 1, 0, 0, 0, 0, 4'd0, 0);
        tick();
        n_tests++;
        if (alarmSources !== 6'b100000 || alarmActive !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_pending got=%b act=%b exp=100000 act=0",
                     alarmSources, alarmActive);
        end
        drive(1, 0, 0, 0, 0, 0, 4'd0, 0);
        tick();
        n_tests++;
        if (alarmActive !== 1'b1 || alarmCode !== 3'd1 ||
            alarmSources !== 6'b100000 || eventCount !== 8'd1) begin
            n_fail++;
            $display("FAIL fall_alarm got=%b/%0d/%b/%0d exp=1/1/100000/1",
                     alarmActive, alarmCode, alarmSources, eventCount);
        end
    endtask

    task automatic test_pressure();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 0, 0, 0, 4'd0, 0);
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 0, 0, 0, 0, 4'd0, 0);
            tick();
            n_tests++;
            if (alarmActive !== 1'b0 || alarmSources !== 6'd0) begin
                n_fail++;
                $display("FAIL press3_noalarm got act=%b src=%b exp=0/000000",
                         alarmActive, alarmSources);
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, 0, 0, 0, 4'd0, 0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 4'd0, 0);
        tick();
        n_tests++;
        if (alarmActive !== 1'b1 || alarmCode !== 3'd2 ||
            alarmSources !== 6'b010000) begin
            n_fail++;
            $display("FAIL press4_alarm got=%b/%0d/%b exp=1/2/010000",
                     alarmActive, alarmCode, alarmSources);
        end
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, 0, 0, 0, 4'd0, 0);
            tick();
            if (k < 3) begin
                n_tests++;
                if (alarmSources !== 6'd0) begin
                    n_fail++;
                    $display("FAIL gap_early_%0d got src=%b exp=000000",
                             k, alarmSources);
                end
            end
            drive(0, 0, 1'($urandom_range(0, 1)), 0, 0, 0, 4'd0, 0);
            tick();
            tick();
        end
        n_tests++;
        if (alarmActive !== 1'b1 || alarmCode !== 3'd2) begin
            n_fail++;
            $display("FAIL gap_alarm got=%b/%0d exp=1/2",
                     alarmActive, alarmCode);
        end
    endtask

    task automatic test_gi();
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 0, 0, 0, 0, 4'd11, 0);
            tick();
            n_tests++;
            if (alarmActive !== 1'b0 || alarmSources !== 6'd0) begin
                n_fail++;
                $display("FAIL gi11_%0d got act=%b src=%b exp=0/000000",
                         k, alarmActive, alarmSources);
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0, 0, 0, 4'd12, 0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 4'd0, 0);
        tick();
        n_tests++;
        if (alarmActive !== 1'b1 || alarmCode !== 3'd6 ||
            alarmSources !== 6'b000001) begin
            n_fail++;
            $display("FAIL gi12_alarm got=%b/%0d/%b exp=1/6/000001",
                     alarmActive, alarmCode, alarmSources);
        end
    endtask

    task automatic test_ack_cooldown();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 1, 0, 0, 4'd0, 0);
            tick();
        end
        n_tests++;
        if (alarmActive !== 1'b1 || alarmCode !== 3'd3 || eventCount !== 8'd1) begin
            n_fail++;
            $display("FAIL blood_alarm got=%b/%0d/%0d exp=1/3/1",
                     alarmActive, alarmCode, eventCount);
        end
        drive(1, 0, 0, 1, 0, 0, 4'd0, 1);
        tick();
        for (int k = 1; k <= 8; k++) begin
            n_tests++;
            if (alarmActive !== 1'b0) begin
                n_fail++;
                $display("FAIL cooldown_%0d got act=%b exp=0", k, alarmActive);
            end
            // Acks during cooldown must be ignored.
            drive(1, 0, 0, 1, 0, 0, 4'd0, 1'(k % 2));
            tick();
        end
        n_tests++;
        if (alarmActive !== 1'b1 || eventCount !== 8'd2 ||
            alarmSources !== 6'b001000) begin
            n_fail++;
            $display("FAIL realarm got=%b/%0d/%b exp=1/2/001000",
                     alarmActive, eventCount, alarmSources);
        end
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 1, 0, 0, 4'd0, 0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 4'd0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 4'd0, 1);
        tick();
        n_tests++;
        if (alarmActive !== 1'b0 || alarmSources !== 6'd0) begin
            n_fail++;
            $display("FAIL ack_clear got act=%b src=%b exp=0/000000",
                     alarmActive, alarmSources);
        end
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 0, 0, 0, 0, 4'd0, 0);
            tick();
            n_tests++;
            if (alarmActive !== 1'b0 || eventCount !== 8'd1) begin
                n_fail++;
                $display("FAIL to_idle_%0d got act=%b cnt=%0d exp=0/1",
                         k, alarmActive, eventCount);
            end
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 1, 4'd0, 0);
            tick();
        end
        drive(1, 1, 0, 0, 0, 1, 4'd0, 0);
        tick();
        n_tests++;
        if (alarmSources !== 6'b100010 || alarmActive !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_pending got src=%b act=%b exp=100010/0",
                     alarmSources, alarmActive);
        end
        drive(1, 0, 0, 0, 0, 0, 4'd0, 0);
        tick();
        n_tests++;
        if (alarmActive !== 1'b1 || alarmCode !== 3'd1 ||
            alarmSources !== 6'b100010) begin
            n_fail++;
            $display("FAIL simul_alarm got=%b/%0d/%b exp=1/1/100010",
                     alarmActive, alarmCode, alarmSources);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({alarmActive, alarmCode, alarmSources, eventCount} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset got=%b/%0d/%b/%0d exp=all zero",
                     alarmActive, alarmCode, alarmSources, eventCount);
        end
    endtask

    task automatic test_random();
        logic [4:0] hold;
        apply_reset();
        hold = '0;
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 7) == 0) hold[b] = ~hold[b];
            end
            rst = ($urandom_range(0, 299) == 0);
            drive(1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 39) == 0),
                  hold[4], hold[3], hold[2], hold[1],
                  hold[0] ? 4'($urandom_range(GIH, 15)) :
                            4'($urandom_range(0, GIH - 1)),
                  1'($urandom_range(0, 3) == 0));
            tick();
            n_tests++;
            if (alarmActive !== (m_mode == 1) || alarmCode !== exp_code() ||
                alarmSources !== m_pend || eventCount !== CW'(m_cnt)) begin
                n_fail++;
                $display("FAIL random_%0d got=%b/%0d/%b/%0d exp=%b/%0d/%b/%0d",
                         k, alarmActive, alarmCode, alarmSources, eventCount,
                         (m_mode == 1), exp_code(), m_pend, m_cnt);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < 3200; k++) begin
            drive(1, 1, 0, 0, 0, 0, 4'd0, 1'(m_mode == 1));
            tick();
            n_tests++;
            if (eventCount !== CW'(m_cnt) || alarmActive !== (m_mode == 1)) begin
                n_fail++;
                $display("FAIL sat_%0d got cnt=%0d act=%b exp=%0d/%b",
                         k, eventCount, alarmActive, m_cnt, (m_mode == 1));
            end
        end
        n_tests++;
        if (eventCount !== 8'hFF) begin
            n_fail++;
            $display("FAIL sat_final got=%0d exp=255", eventCount);
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) streak[i] = 0;
        test_reset();
        test_fall();
        test_pressure();
        test_gi();
        test_ack_cooldown();
        test_simultaneous();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
